// File: rtl/chain_lane_scheduler.sv
// Round-robin scheduler that unloads capture chains onto a smaller pool of shared output lanes.
// Optional per-lane stall timeout is built when CHAIN_TIMEOUT_EN is defined.
module chain_lane_scheduler #(
    parameter int CHAINS_IN  = 5,
    parameter int CHAINS_OUT = 3,
    parameter int CHAIN_LEN  = 16,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHAINS_IN-1:0]        req,
    input  logic [CHAINS_OUT-1:0]       lane_rdy,
    output logic [CHAINS_IN-1:0]        chain_shift,
    output logic [CHAINS_OUT-1:0]       lane_valid,
    output logic [CHAINS_OUT*SEL_W-1:0] lane_sel,
    output logic [CHAINS_IN-1:0]        chain_done,
    output logic [CHAINS_IN-1:0]        chain_abort,
    output logic                        busy
);

    // state | meaning
    // IDLE  | lane free, lane_sel keeps last owner
    // SHIFT | lane owned, one bit moves per lane_rdy cycle
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} lane_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    lane_state_t          state_q [CHAINS_OUT];
    lane_state_t          state_d [CHAINS_OUT];
    logic [CNT_W-1:0]     cnt_q   [CHAINS_OUT];
    logic [CNT_W-1:0]     cnt_d   [CHAINS_OUT];
    logic [SEL_W-1:0]     owner_q [CHAINS_OUT];
    logic [SEL_W-1:0]     owner_d [CHAINS_OUT];
    logic [SEL_W-1:0]     rr_q, rr_d;
    logic [CHAINS_IN-1:0] done_d;
    logic [CHAINS_IN-1:0] owned, eligible, rot;
    logic [2*CHAINS_IN-1:0] elig2;
    logic                 win_found, lane_found, grant;
    logic [SEL_W-1:0]     win;
    int                   grant_lane;

`ifdef CHAIN_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    logic [STALL_W-1:0]   stall_q [CHAINS_OUT];
    logic [STALL_W-1:0]   stall_d [CHAINS_OUT];
    logic [CHAINS_IN-1:0] abort_d, abort_q;
`endif

    // Arbitration: rotate the eligible vector so bit 0 is the chain at rr.
    always_comb begin
        int w;
        owned      = '0;
        win_found  = 1'b0;
        win        = '0;
        lane_found = 1'b0;
        grant_lane = 0;
        w          = 0;
        for (int j = 0; j < CHAINS_OUT; j++)
            for (int i = 0; i < CHAINS_IN; i++)
                if (state_q[j] == SHIFT && owner_q[j] == SEL_W'(i))
                    owned[i] = 1'b1;
        eligible = req & ~owned;
        elig2    = {eligible, eligible} >> rr_q;
        rot      = elig2[CHAINS_IN-1:0];
        for (int k = 0; k < CHAINS_IN; k++) begin
            if (!win_found && rot[k]) begin
                win_found = 1'b1;
                w = int'(rr_q) + k;
                if (w >= CHAINS_IN) w = w - CHAINS_IN;
                win = SEL_W'(w);
            end
        end
        for (int j = 0; j < CHAINS_OUT; j++) begin
            if (!lane_found && state_q[j] == IDLE) begin
                lane_found = 1'b1;
                grant_lane = j;
            end
        end
        grant = win_found & lane_found;
        rr_d  = rr_q;
        if (grant)
            rr_d = (win == SEL_W'(CHAINS_IN - 1)) ? '0 : win + SEL_W'(1);
    end

    always_comb begin
        chain_shift = '0;
        done_d      = '0;
`ifdef CHAIN_TIMEOUT_EN
        abort_d     = '0;
`endif
        for (int j = 0; j < CHAINS_OUT; j++) begin
            state_d[j] = state_q[j];
            cnt_d[j]   = cnt_q[j];
            owner_d[j] = owner_q[j];
`ifdef CHAIN_TIMEOUT_EN
            stall_d[j] = stall_q[j];
`endif
            case (state_q[j])
                IDLE: begin
                    if (grant && grant_lane == j) begin
                        state_d[j] = SHIFT;
                        owner_d[j] = win;
                        cnt_d[j]   = '0;
`ifdef CHAIN_TIMEOUT_EN
                        stall_d[j] = '0;
`endif
                    end
                end
                SHIFT: begin
                    if (lane_rdy[j]) begin
                        for (int i = 0; i < CHAINS_IN; i++)
                            if (owner_q[j] == SEL_W'(i)) chain_shift[i] = 1'b1;
`ifdef CHAIN_TIMEOUT_EN
                        stall_d[j] = '0;
`endif
                        if (cnt_q[j] == CNT_LAST) begin
                            state_d[j] = IDLE;
                            cnt_d[j]   = '0;
                            for (int i = 0; i < CHAINS_IN; i++)
                                if (owner_q[j] == SEL_W'(i)) done_d[i] = 1'b1;
                        end else begin
                            cnt_d[j] = cnt_q[j] + CNT_W'(1);
                        end
                    end
`ifdef CHAIN_TIMEOUT_EN
                    else if (stall_q[j] == STALL_LAST) begin
                        state_d[j] = IDLE;
                        cnt_d[j]   = '0;
                        stall_d[j] = '0;
                        for (int i = 0; i < CHAINS_IN; i++)
                            if (owner_q[j] == SEL_W'(i)) abort_d[i] = 1'b1;
                    end else begin
                        stall_d[j] = stall_q[j] + STALL_W'(1);
                    end
`endif
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            chain_done <= '0;
            for (int j = 0; j < CHAINS_OUT; j++) begin
                state_q[j] <= IDLE;
                cnt_q[j]   <= '0;
                owner_q[j] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            chain_done <= done_d;
            for (int j = 0; j < CHAINS_OUT; j++) begin
                state_q[j] <= state_d[j];
                cnt_q[j]   <= cnt_d[j];
                owner_q[j] <= owner_d[j];
            end
        end
    end

`ifdef CHAIN_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= '0;
            for (int j = 0; j < CHAINS_OUT; j++) stall_q[j] <= '0;
        end else begin
            abort_q <= abort_d;
            for (int j = 0; j < CHAINS_OUT; j++) stall_q[j] <= stall_d[j];
        end
    end
    assign chain_abort = abort_q;
`else
    assign chain_abort = '0;
`endif

    for (genvar j = 0; j < CHAINS_OUT; j++) begin : g_lane_out
        assign lane_valid[j]              = (state_q[j] == SHIFT);
        assign lane_sel[j*SEL_W +: SEL_W] = owner_q[j];
    end

    assign busy = |lane_valid;

endmodule

// File: tb/tb_chain_lane_scheduler.sv
// Directed bench for chain_lane_scheduler: grant latency, oversubscription, fairness,
// backpressure, asynchronous reset and stall timeout (CHAIN_TIMEOUT_EN aware).
module tb_chain_lane_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic [2:0] lane_rdy = '0;
    logic [4:0] chain_shift, chain_done, chain_abort;
    logic [2:0] lane_valid;
    logic [8:0] lane_sel;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int shifts;

    chain_lane_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lane_rdy    (lane_rdy),
        .chain_shift (chain_shift),
        .lane_valid  (lane_valid),
        .lane_sel    (lane_sel),
        .chain_done  (chain_done),
        .chain_abort (chain_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, drive inputs just after the edge, sample 1 ns later.
    task automatic step(input logic [4:0] r, input logic [2:0] rdy);
        @(posedge clk);
        #1;
        req      = r;
        lane_rdy = rdy;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_shift"}, 32'(chain_shift), 0);
        chk({tag, "_valid"}, 32'(lane_valid), 0);
        chk({tag, "_sel"},   32'(lane_sel), 0);
        chk({tag, "_done"},  32'(chain_done), 0);
        chk({tag, "_abort"}, 32'(chain_abort), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        lane_rdy = '0;
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Single request on chain 2
        do_reset();
        step('b00100, 'b111);
        chk("t1_pre_valid", 32'(lane_valid), 0);
        step('b00000, 'b111);
        chk("t1_valid", 32'(lane_valid), 'b001);
        chk("t1_sel0",  32'(lane_sel[2:0]), 2);
        chk("t1_shift", 32'(chain_shift), 'b00100);
        chk("t1_busy",  32'(busy), 1);
        for (int c = 2; c <= 16; c++) begin
            step('b00000, 'b111);
            chk("t1_shift_run", 32'(chain_shift), 'b00100);
            chk("t1_done_early", 32'(chain_done), 0);
        end
        step('b00000, 'b111);
        chk("t1_done",      32'(chain_done), 'b00100);
        chk("t1_valid_off", 32'(lane_valid), 0);
        chk("t1_busy_off",  32'(busy), 0);
        chk("t1_shift_off", 32'(chain_shift), 0);
        step('b00000, 'b111);
        chk("t1_done_once", 32'(chain_done), 0);

        // Oversubscription: all five chains request
        do_reset();
        step('b11111, 'b111);
        step('b11111, 'b111);
        chk("t2_c1_valid", 32'(lane_valid), 'b001);
        chk("t2_c1_sel",   32'(lane_sel), 'h000);
        step('b11111, 'b111);
        chk("t2_c2_valid", 32'(lane_valid), 'b011);
        chk("t2_c2_sel",   32'(lane_sel), 'h008);
        step('b11111, 'b111);
        chk("t2_c3_valid", 32'(lane_valid), 'b111);
        chk("t2_c3_sel",   32'(lane_sel), 'h088);
        chk("t2_c3_shift", 32'(chain_shift), 'b00111);
        for (int c = 4; c <= 16; c++) step('b11111, 'b111);
        step('b11111, 'b111);
        chk("t2_c17_valid", 32'(lane_valid), 'b110);
        chk("t2_c17_done",  32'(chain_done), 'b00001);
        chk("t2_c17_shift", 32'(chain_shift), 'b00110);
        step('b11111, 'b111);
        chk("t2_c18_valid", 32'(lane_valid), 'b101);
        chk("t2_c18_sel",   32'(lane_sel), 'h08B);
        chk("t2_c18_done",  32'(chain_done), 'b00010);
        chk("t2_c18_shift", 32'(chain_shift), 'b01100);
        step('b11111, 'b111);
        chk("t2_c19_valid", 32'(lane_valid), 'b011);
        chk("t2_c19_sel",   32'(lane_sel), 'h0A3);
        chk("t2_c19_shift", 32'(chain_shift), 'b11000);
        step('b11111, 'b111);
        chk("t2_c20_valid", 32'(lane_valid), 'b111);
        chk("t2_c20_sel",   32'(lane_sel), 'h023);

        // Fairness: lanes 1,2 stalled, chain 0 re-requests while chain 4 waits
        do_reset();
        step('b00111, 'b001);
        step('b10111, 'b001);
        chk("t3_c1_valid", 32'(lane_valid), 'b001);
        chk("t3_c1_sel0",  32'(lane_sel[2:0]), 0);
        step('b10111, 'b001);
        chk("t3_c2_valid", 32'(lane_valid), 'b011);
        step('b10111, 'b001);
        chk("t3_c3_sel",   32'(lane_sel), 'h088);
        for (int c = 4; c <= 16; c++) step('b10111, 'b001);
        step('b10111, 'b001);
        chk("t3_c17_valid", 32'(lane_valid), 'b110);
        chk("t3_c17_done",  32'(chain_done), 'b00001);
        step('b00111, 'b001);
        chk("t3_c18_valid", 32'(lane_valid), 'b111);
        chk("t3_c18_sel0",  32'(lane_sel[2:0]), 4);
        chk("t3_c18_shift", 32'(chain_shift), 'b10000);
        for (int c = 19; c <= 33; c++) step('b00111, 'b001);
        step('b00111, 'b001);
        chk("t3_c34_done",  32'(chain_done), 'b10000);
        chk("t3_c34_valid", 32'(lane_valid), 'b110);
        step('b00111, 'b001);
        chk("t3_c35_valid", 32'(lane_valid), 'b111);
        chk("t3_c35_sel0",  32'(lane_sel[2:0]), 0);

        // Backpressure: lane_rdy[0] alternates 1,0
        do_reset();
        step('b00001, 'b000);
        shifts = 0;
        for (int c = 1; c <= 31; c++) begin
            step('b00000, {2'b00, (c % 2 == 1)});
            chk("t4_shift", 32'(chain_shift), (c % 2 == 1) ? 1 : 0);
            if (chain_shift[0]) shifts++;
        end
        step('b00000, 'b000);
        chk("t4_shift_count", shifts, 16);
        chk("t4_done",  32'(chain_done), 'b00001);
        chk("t4_valid", 32'(lane_valid), 0);

        // Asynchronous reset in cycle 8 of an unload, then full restart
        do_reset();
        step('b00001, 'b111);
        for (int c = 1; c <= 8; c++) step('b00001, 'b111);
        chk("t5_c8_shift", 32'(chain_shift), 'b00001);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        shifts = 0;
        for (int c = 1; c <= 16; c++) begin
            step('b00000, 'b111);
            if (chain_shift[0]) shifts++;
            chk("t5_done_early", 32'(chain_done), 0);
        end
        chk("t5_shift_count", shifts, 16);
        step('b00000, 'b111);
        chk("t5_done",  32'(chain_done), 'b00001);
        chk("t5_valid", 32'(lane_valid), 0);

        // Stall timeout with lane_rdy held low
        do_reset();
        step('b00001, 'b000);
        step('b00000, 'b000);
        chk("t6_c1_valid", 32'(lane_valid), 'b001);
        chk("t6_c1_shift", 32'(chain_shift), 0);
        for (int c = 2; c <= 64; c++) step('b00000, 'b000);
        chk("t6_c64_valid", 32'(lane_valid), 'b001);
        chk("t6_c64_abort", 32'(chain_abort), 0);
        step('b00000, 'b000);
`ifdef CHAIN_TIMEOUT_EN
        chk("t6_c65_valid", 32'(lane_valid), 0);
        chk("t6_c65_abort", 32'(chain_abort), 'b00001);
        chk("t6_c65_done",  32'(chain_done), 0);
        step('b00000, 'b000);
        chk("t6_c66_abort", 32'(chain_abort), 0);
`else
        chk("t6_c65_valid", 32'(lane_valid), 'b001);
        chk("t6_c65_abort", 32'(chain_abort), 0);
        for (int c = 66; c <= 70; c++) step('b00000, 'b000);
        chk("t6_c70_valid", 32'(lane_valid), 'b001);
        chk("t6_c70_abort", 32'(chain_abort), 0);
        chk("t6_c70_done",  32'(chain_done), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chain_lane_scheduler.md
# chain_lane_scheduler

Schedules unloading of captured shadow scan chains onto a smaller set of shared output lanes. Each capture chain raises a request when it holds data. The scheduler grants free lanes to requesting chains in round-robin order and drives the per-chain shift enables. It counts shifted bits against the chain length and releases each lane when its chain has been fully unloaded. It sits between the capture chains and the chain routing controller, and provides that controller's lane-select information.

## Interface
- CHAINS_IN, 5, number of capture chains (requesters)
- CHAINS_OUT, 3, number of output lanes (CHAINS_OUT <= CHAINS_IN)
- CHAIN_LEN, 16, bits per chain (>= 2)
- SEL_W, 3, width of one lane-select field, >= ceil(log2(CHAINS_IN))
- CNT_W, 5, bit-counter width, 2**CNT_W > CHAIN_LEN
- TIMEOUT, 64, stall limit in cycles (used only with CHAIN_TIMEOUT_EN)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  CHAINS_IN  chain i holds captured data awaiting unload
- lane_rdy  in  CHAINS_OUT  lane j accepts one bit this cycle
- chain_shift  out  CHAINS_IN  shift enable to chain i
- lane_valid  out  CHAINS_OUT  lane j is owned by a chain
- lane_sel  out  CHAINS_OUT*SEL_W  owning chain index of lane j, in bits [j*SEL_W +: SEL_W]
- chain_done  out  CHAINS_IN  one-cycle pulse when chain i finishes unloading
- chain_abort  out  CHAINS_IN  one-cycle pulse on timeout; tied 0 without the macro
- busy  out  1  OR of lane_valid

## Operation
- Each lane runs its own state machine with states IDLE and SHIFT, plus a bit counter cnt and an owner register.
- **Arbitration:**
  - At most one grant per cycle.
  - Eligible chains have req=1 and are not currently owned by any lane.
  - Search starts at pointer rr and wraps upward; the first eligible chain wins.
  - The winner goes to the lowest-index IDLE lane.
  - On a grant, rr <= (winner+1) mod CHAINS_IN; otherwise rr holds.
- **Grant:** the lane moves IDLE→SHIFT, owner <= winner, cnt <= 0.
- **Shift:**
  - chain_shift[owner] = lane in SHIFT & lane_rdy[lane]. This is combinational from registered state and lane_rdy.
  - Each shift increments cnt.
  - Non-owned chains have chain_shift=0.
- **Completion:**
  - A shift with cnt==CHAIN_LEN-1 moves the lane SHIFT→IDLE.
  - chain_done[owner] pulses in the following cycle.
- **Re-request:** a chain becomes eligible again in the cycle its chain_done is high. Requesters must drop req by then if they have no new data.
- lane_sel holds the last owner value while the lane is IDLE. It is qualified by lane_valid.
- chain_done and chain_abort are registered outputs.

## Timing
- **Reset values:**
  - All lanes IDLE, cnt=0, owner=0, rr=0.
  - chain_shift, lane_valid, lane_sel, chain_done, chain_abort and busy are all 0.
- **Reset assertion:** takes effect immediately and asynchronously, including mid-shift. Partial unloads are discarded. A chain still requesting after reset restarts from cnt=0.
- **Request to grant:** req sampled high at edge N gives lane_valid=1 during cycle N+1, and first shift possible in cycle N+1.
- **Unload length:** with lane_rdy held high, exactly CHAIN_LEN shift cycles, and chain_done one cycle after the last one.
- **Lane reuse:** a lane freed at edge E is grantable at edge E+1 at the earliest (IDLE for ≥1 cycle). Arbitration uses current-cycle IDLE status only.
- **Contention:**
  - Simultaneous requests are served one per cycle.
  - With all lanes busy, requests wait without loss; req is level-sensitive.
- **Backpressure:** lane_rdy=0 freezes cnt and holds chain_shift=0. The grant is never revoked by backpressure, except by timeout.

## Configuration
- **CHAIN_TIMEOUT_EN defined:**
  - Each lane has a stall counter that counts consecutive SHIFT cycles with lane_rdy=0 and is cleared by any shift.
  - When it reaches TIMEOUT, the lane returns to IDLE and chain_abort[owner] pulses the next cycle; chain_done does not pulse.
  - The chain is eligible again immediately afterwards.
- **CHAIN_TIMEOUT_EN undefined:**
  - No stall counters are built and chain_abort is constant 0.
  - A lane stalls indefinitely.

## Test plan
- **Single request:** req=5'b00100 held one cycle past grant, lane_rdy=3'b111 → lane_valid=3'b001 and lane_sel[2:0]=2 next cycle; chain_shift[2] high 16 consecutive cycles; chain_done[2] pulses once; busy falls with lane_valid.
- **Oversubscription:** req=5'b11111, all lanes ready:
  - Chains 0, 1, 2 are granted lanes 0, 1, 2 on three consecutive cycles; chains 3 and 4 wait.
  - Chain 3 takes lane 0 after chain 0 completes and the lane has been IDLE for one cycle; chain 4 then takes lane 1.
- **Backpressure:** single grant, lane_rdy[0] alternating 1,0 → exactly 16 chain_shift pulses, matching lane_rdy; chain_done after ~32 cycles; cnt never exceeds 15.
- **Fairness:** chain 0 re-requests continuously with CHAINS_OUT effectively busy except lane 0, while chain 4 is waiting → chain 4 is granted before chain 0's second grant.
- **Reset mid-operation:** rst_n low during cycle 8 of a shift → every output is 0 without waiting for a clock edge; after release with req still high, regrant starts at cnt=0 and 16 full shifts are observed.
- **Timeout (CHAIN_TIMEOUT_EN, TIMEOUT=64):** lane_rdy[0]=0 after grant:
  - With the macro: chain_abort pulses 64 cycles later, lane_valid[0] drops, and there is no chain_done.
  - Without the macro: the lane stays valid and chain_abort stays 0.
